// File: rtl/fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// fifo_stream_reader
//
// Read-side controller for the team's synchronous single-clock FIFO. It pops
// words out of the FIFO whenever there is room for them, absorbs the FIFO's
// one-cycle registered read latency in a 2-entry prefetch buffer, and presents
// the words downstream on a valid/ready stream at up to one word per cycle.
// It also keeps a running count of the words delivered downstream.
//
// Parameters
//   DATA_WIDTH  FIFO word and stream data width
//   CNT_WIDTH   width of the delivered-word counter (wraps, no saturation)
//
// Ports
//   clk         clock, all logic on the rising edge
//   rst         asynchronous active-high reset
//   en          allow new FIFO pops (buffered/in-flight words still drain)
//   fifo_empty  FIFO empty flag (registered inside the FIFO)
//   fifo_data   FIFO read data, valid the cycle after a pop
//   fifo_rd_cs  FIFO read chip select (equal to the pop strobe)
//   fifo_rd_en  FIFO read enable (equal to the pop strobe)
//   out_valid   out_data holds a word
//   out_ready   consumer accepts the word this cycle
//   out_data    head word of the prefetch buffer
//   words_out   count of completed out_valid && out_ready transfers
//   busy        buffer non-empty or a pop is in flight
//   out_parity  even parity (XOR reduction) of out_data, only present when
//               FIFO_STREAM_READER_PARITY_EN is defined
//
// Optional feature macro: FIFO_STREAM_READER_PARITY_EN
// ---------------------------------------------------------------------------
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_cs,
    output logic                  fifo_rd_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  words_out,
    output logic                  busy
`ifdef FIFO_STREAM_READER_PARITY_EN
    ,
    output logic                  out_parity
`endif
);

    // Buffer state: occupancy (0..2), in-flight flag and the two entries.
    // Entry 0 is always the head of the stream.
    logic [1:0]            occ;
    logic                  infl;
    logic [DATA_WIDTH-1:0] entry0;
    logic [DATA_WIDTH-1:0] entry1;
    logic [CNT_WIDTH-1:0]  word_cnt;

    // Next-state values and handshake terms.
    logic                  take;
    logic                  pop;
    logic [1:0]            occ_next;
    logic [DATA_WIDTH-1:0] entry0_next;
    logic [DATA_WIDTH-1:0] entry1_next;

    // Handshake, pop decision and next buffer contents.
    // occ + infl never exceeds 2: a pop is only issued when the resulting
    // occupancy leaves a free slot, so the 2-bit occ_next cannot overflow.
    // The take term credits a slot in the same cycle the consumer accepts a
    // word, which lets the pop continue back-to-back at full throughput and
    // makes out_ready -> fifo_rd_en a single combinational level.
    // On a take entry 1 shifts into entry 0; an arriving word is then written
    // to index occ_next-1, so an arrival into entry 0 overrides the shift.
    always_comb begin
        take        = (occ != 2'd0) && out_ready;
        occ_next    = occ + {1'b0, infl} - {1'b0, take};
        pop         = en && !fifo_empty && (occ_next < 2'd2);
        entry0_next = entry0;
        entry1_next = entry1;
        if (take) begin
            entry0_next = entry1;
        end
        if (infl) begin
            if (occ_next == 2'd1) begin
                entry0_next = fifo_data;
            end else begin
                entry1_next = fifo_data;
            end
        end
    end

    // Register update. The in-flight flag remembers that the FIFO will
    // present a word on fifo_data during the next cycle. Reset discards
    // anything buffered or in flight; the FIFO itself shares this reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ      <= 2'd0;
            infl     <= 1'b0;
            entry0   <= '0;
            entry1   <= '0;
            word_cnt <= '0;
        end else begin
            occ    <= occ_next;
            infl   <= pop;
            entry0 <= entry0_next;
            entry1 <= entry1_next;
            if (take) begin
                word_cnt <= word_cnt + 1'b1;
            end
        end
    end

    // Outputs. out_valid and out_data depend only on registered state, so
    // there is no path from out_ready to either of them.
    always_comb begin
        fifo_rd_cs = pop;
        fifo_rd_en = pop;
        out_valid  = (occ != 2'd0);
        out_data   = entry0;
        words_out  = word_cnt;
        busy       = (occ != 2'd0) || infl;
    end

`ifdef FIFO_STREAM_READER_PARITY_EN
    // Parity follows the head entry, so it changes together with out_data
    // and reads 0 out of reset when the entry is cleared.
    always_comb begin
        out_parity = ^entry0;
    end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_stream_reader
//
// Self-checking bench for fifo_stream_reader. A behavioural FIFO feeds the
// DUT, and a reference model built from pop/take counters plus an in-order
// scoreboard queue predicts every output each cycle. The counter is built
// 4 bits wide so wrap-around is reached quickly.
// ---------------------------------------------------------------------------
module tb_fifo_stream_reader;

    localparam int DW    = 8;
    localparam int CW    = 4;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_rd_cs;
    logic          fifo_rd_en;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] words_out;
    logic          busy;
`ifdef FIFO_STREAM_READER_PARITY_EN
    logic          out_parity;
`endif

    logic          push_req;
    logic [DW-1:0] push_val;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    int pops;
    int takes;
    int arrived;

    fifo_stream_reader #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_cs (fifo_rd_cs),
        .fifo_rd_en (fifo_rd_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .words_out  (words_out),
        .busy       (busy)
`ifdef FIFO_STREAM_READER_PARITY_EN
        ,
        .out_parity (out_parity)
`endif
    );

    always #5 clk = ~clk;

    // Compare one observed value against the bench's expectation.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, actual, expected, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one cycle's worth of inputs just after the rising edge.
    task automatic applyStimulus(input logic p, input logic [DW-1:0] v,
                                 input logic rdy, input logic e);
        @(posedge clk);
        #1;
        push_req  = p;
        push_val  = v;
        out_ready = rdy;
        en        = e;
    endtask

    // Behavioural FIFO: registered read data and registered empty flag.
    // Every accepted push is also recorded in the scoreboard queue.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_q.delete();
            exp_q.delete();
            fifo_empty <= 1'b1;
            fifo_data  <= '0;
        end else begin
            if (fifo_rd_cs && fifo_rd_en && fifo_q.size() > 0) begin
                fifo_data <= fifo_q.pop_front();
            end
            if (push_req && fifo_q.size() < DEPTH) begin
                fifo_q.push_back(push_val);
                exp_q.push_back(push_val);
            end
            fifo_empty <= (fifo_q.size() == 0);
        end
    end

    // Reference model, evaluated mid-cycle. Words popped two or more cycles
    // ago minus words taken is what the buffer holds; words popped minus
    // words taken is what is buffered or still in flight.
    always @(negedge clk) begin : sampler
        bit            exp_valid;
        bit            exp_take;
        bit            exp_pop;
        logic [DW-1:0] head;
        if (rst) begin
            pops    = 0;
            takes   = 0;
            arrived = 0;
            checkOutput("rst_rd_en", fifo_rd_en, 0);
            checkOutput("rst_valid", out_valid, 0);
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_words", words_out, 0);
        end else begin
            exp_valid = (arrived - takes) > 0;
            exp_take  = exp_valid && out_ready;
            exp_pop   = en && !fifo_empty && ((pops - takes - int'(exp_take)) < 2);
            checkOutput("out_valid", out_valid, exp_valid);
            checkOutput("busy", busy, (pops - takes) > 0);
            checkOutput("fifo_rd_en", fifo_rd_en, exp_pop);
            checkOutput("fifo_rd_cs", fifo_rd_cs, exp_pop);
            checkOutput("words_out", words_out, takes % (1 << CW));
            if (fifo_empty) begin
                checkOutput("pop_when_empty", fifo_rd_en, 0);
            end
            if (exp_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("scoreboard_empty", exp_q.size(), 1);
                end else begin
                    head = exp_q[0];
                    checkOutput("out_data", out_data, head);
`ifdef FIFO_STREAM_READER_PARITY_EN
                    checkOutput("out_parity", out_parity, ^head);
`endif
                    if (exp_take) begin
                        void'(exp_q.pop_front());
                    end
                end
            end
            arrived = pops;
            pops    = pops + int'(exp_pop);
            takes   = takes + int'(exp_take);
        end
    end

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        out_ready = 1'b0;
        push_req  = 1'b0;
        push_val  = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_data", out_data, 0);
        checkOutput("reset_busy", busy, 0);
        rst = 1'b0;

        // Idle with an empty FIFO.
        repeat (5) applyStimulus(1'b0, '0, 1'b1, 1'b1);

        // Single word.
        applyStimulus(1'b1, 8'hA5, 1'b1, 1'b1);
        repeat (6) applyStimulus(1'b0, '0, 1'b1, 1'b1);
        checkOutput("single_count", words_out, 1);

        // Streaming 16 preloaded words.
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, DW'(i), 1'b1, 1'b0);
        repeat (22) applyStimulus(1'b0, '0, 1'b1, 1'b1);
        checkOutput("stream_count", words_out, 17 % 16);

        // Back-pressure mid-stream.
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, DW'(8'h40 + i), 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, '0, 1'b1, 1'b1);
        repeat (7) applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("stall_rd_en", fifo_rd_en, 0);
        checkOutput("stall_valid", out_valid, 1);
        repeat (14) applyStimulus(1'b0, '0, 1'b1, 1'b1);
        checkOutput("bp_count", words_out, 25 % 16);

        // en gating: one pop in flight, then en low.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, DW'(8'h60 + i), 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        repeat (5) applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("en_gate_idle", busy, 0);
        checkOutput("en_gate_count", words_out, 26 % 16);
        repeat (8) applyStimulus(1'b0, '0, 1'b1, 1'b1);
        checkOutput("en_resume_count", words_out, 28 % 16);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), DW'($urandom),
                          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0));
        end

        // Drain, bounded.
        begin
            int cyc;
            cyc = 0;
            applyStimulus(1'b1, 8'h07, 1'b1, 1'b1);
            while ((busy || !fifo_empty) && cyc < 200) begin
                applyStimulus(1'b0, '0, 1'b1, 1'b1);
                cyc++;
            end
            repeat (2) applyStimulus(1'b0, '0, 1'b1, 1'b1);
            checkOutput("drain_busy", busy, 0);
            checkOutput("drain_empty", fifo_empty, 1);
        end

        // Asynchronous reset with two words buffered.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, DW'(8'h80 + i), 1'b1, 1'b0);
        repeat (5) applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("pre_reset_valid", out_valid, 1);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_valid", out_valid, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_rd_en", fifo_rd_en, 0);
        checkOutput("mid_rst_rd_cs", fifo_rd_cs, 0);
        checkOutput("mid_rst_words", words_out, 0);
        checkOutput("mid_rst_data", out_data, 0);
`ifdef FIFO_STREAM_READER_PARITY_EN
        checkOutput("mid_rst_parity", out_parity, 0);
`endif
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Counter wrap: 17 words on a 4-bit counter.
        for (int i = 0; i < 17; i++) applyStimulus(1'b1, DW'(8'hC0 + i), 1'b1, 1'b0);
        repeat (25) applyStimulus(1'b0, '0, 1'b1, 1'b1);
        checkOutput("wrap_17", words_out, 1);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
